// File: rtl/ecies_hash_arbiter.sv
// Round-robin arbiter sharing one SHA core among NUM_CH level-handshake hash requesters.
// Latency: hash_go rises two edges after an idle request; req_done rises one edge after the hash_done capture edge.
// Backpressure: holds in ISSUE while hash_ready=0; results are kept per channel so a slow requester never stalls others.
// Optional WAIT-state timeout is compiled in with the HASH_ARB_TIMEOUT_EN macro.
module ecies_hash_arbiter #(
    parameter int NUM_CH         = 4,
    parameter int REQ_WIDTH      = 80,
    parameter int HASH_WIDTH     = 512,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              req_go,
    input  logic [NUM_CH*REQ_WIDTH-1:0]    req_data,
    output logic [NUM_CH-1:0]              req_done,
    output logic [NUM_CH*HASH_WIDTH-1:0]   req_hashed,
    output logic [NUM_CH-1:0]              req_err,
    input  logic                           hash_ready,
    output logic                           hash_go,
    output logic [REQ_WIDTH-1:0]           hash_data,
    input  logic                           hash_done,
    input  logic [HASH_WIDTH-1:0]          hash_result,
    output logic [$clog2(NUM_CH)-1:0]      grant_id,
    output logic                           busy
);
    localparam int GW = $clog2(NUM_CH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RELEASE} state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       ptr_q;
    logic [GW-1:0]       grant_d;
    logic                grant_vld;
    logic [NUM_CH-1:0]   done_flag;
    logic [NUM_CH-1:0]   err_flag;
    logic [NUM_CH-1:0]   pending;
    logic                abort_q;
    logic                commit_ok;
    logic                take_grant, do_issue, do_capture, do_timeout;
    logic                tmo_hit;
    int                  idx;

    assign pending   = req_go & ~done_flag & ~err_flag;
    // A result is kept only if the granted channel held its go for the whole transaction.
    assign commit_ok = ~abort_q & req_go[grant_id];
    assign busy      = (state_q != S_IDLE);

    // Round-robin search: first pending channel upward from ptr+1, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_d   = ptr_q;
        idx       = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(ptr_q) + k) % NUM_CH;
            if (!grant_vld && pending[idx]) begin
                grant_vld = 1'b1;
                grant_d   = GW'(idx);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state and per-cycle action strobes.
    always_comb begin
        state_d    = state_q;
        take_grant = 1'b0;
        do_issue   = 1'b0;
        do_capture = 1'b0;
        do_timeout = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    take_grant = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (hash_ready) begin
                    do_issue = 1'b1;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (hash_done) begin
                    do_capture = 1'b1;
                    state_d    = S_RELEASE;
                end else if (tmo_hit) begin
                    do_timeout = 1'b1;
                    state_d    = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!hash_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Grant, core handshake and result capture datapath.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q      <= GW'(NUM_CH - 1);
            grant_id   <= '0;
            hash_go    <= 1'b0;
            hash_data  <= '0;
            abort_q    <= 1'b0;
            req_hashed <= '0;
        end else begin
            if (take_grant) begin
                ptr_q     <= grant_d;
                grant_id  <= grant_d;
                hash_data <= req_data[grant_d*REQ_WIDTH +: REQ_WIDTH];
                abort_q   <= 1'b0;
            end else if ((state_q == S_ISSUE || state_q == S_WAIT) && !req_go[grant_id]) begin
                abort_q <= 1'b1;
            end
            if (do_issue) hash_go <= 1'b1;
            if (do_capture || do_timeout) hash_go <= 1'b0;
            if (do_capture && commit_ok)
                req_hashed[grant_id*HASH_WIDTH +: HASH_WIDTH] <= hash_result;
        end
    end

    // Done flags: dropping go always wins, so a late abort never leaves done set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            done_flag <= '0;
            req_done  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!req_go[i])
                    done_flag[i] <= 1'b0;
                else if (do_capture && commit_ok && grant_id == GW'(i))
                    done_flag[i] <= 1'b1;
            end
            req_done <= done_flag;
        end
    end

`ifdef HASH_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt;

    assign tmo_hit = (state_q == S_WAIT) && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Counts WAIT cycles; cleared whenever the arbiter is outside WAIT.
    always_ff @(posedge clk) begin
        if (!rst)                 tmo_cnt <= '0;
        else if (state_q != S_WAIT) tmo_cnt <= '0;
        else if (!tmo_hit)        tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Error flags: set on timeout of the granted channel, held until its go drops.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_flag <= '0;
            req_err  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!req_go[i])
                    err_flag[i] <= 1'b0;
                else if (do_timeout && grant_id == GW'(i))
                    err_flag[i] <= 1'b1;
            end
            req_err <= err_flag;
        end
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
    assign tmo_hit        = 1'b0;
    assign err_flag       = '0;
    assign req_err        = '0;
`endif

endmodule

// File: tb/tb_ecies_hash_arbiter.sv
// Self-checking bench for ecies_hash_arbiter with a transaction-level round-robin model.
// Latency: checks hash_go/req_done edge timing on directed cases, order and results on random rounds.
// Backpressure: exercises hash_ready stalls in ISSUE and requester aborts during WAIT.
module tb_ecies_hash_arbiter;
    localparam int NCH = 4;
    localparam int RW  = 80;
    localparam int HW  = 512;
    localparam int TMO = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NCH-1:0]    req_go = '0;
    logic [NCH*RW-1:0] req_data = '0;
    logic [NCH-1:0]    req_done;
    logic [NCH*HW-1:0] req_hashed;
    logic [NCH-1:0]    req_err;
    logic              hash_ready = 1'b0;
    logic              hash_go;
    logic [RW-1:0]     hash_data;
    logic              hash_done = 1'b0;
    logic [HW-1:0]     hash_result = '0;
    logic [1:0]        grant_id;
    logic              busy;

    int total = 0;
    int bad   = 0;

    // Reference model state: rotation pointer, payloads, expected result registers.
    int            m_ptr;
    logic [RW-1:0] m_pay    [NCH];
    logic [HW-1:0] m_hashed [NCH];

    ecies_hash_arbiter #(
        .NUM_CH(NCH), .REQ_WIDTH(RW), .HASH_WIDTH(HW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .req_go(req_go), .req_data(req_data),
        .req_done(req_done), .req_hashed(req_hashed), .req_err(req_err),
        .hash_ready(hash_ready), .hash_go(hash_go), .hash_data(hash_data),
        .hash_done(hash_done), .hash_result(hash_result),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [HW-1:0] rnd_hash();
        logic [HW-1:0] r;
        for (int i = 0; i < HW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [RW-1:0] rnd_pay();
        logic [95:0] w;
        w = {$urandom, $urandom, $urandom};
        return w[RW-1:0];
    endfunction

    // Round-robin rule: first requester upward from ptr+1, wrapping.
    function automatic int rr_pick(input logic [NCH-1:0] mask, input int ptr);
        for (int k = 1; k <= NCH; k++) begin
            int c;
            c = (ptr + k) % NCH;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    task automatic load_payloads();
        for (int c = 0; c < NCH; c++) begin
            m_pay[c] = rnd_pay();
            req_data[c*RW +: RW] = m_pay[c];
        end
    endtask

    task automatic release_all();
        req_go = '0;
        repeat (3) tick();
    endtask

    // Behavioural SHA core: waits for hash_go, answers after dly cycles, completes the 4-phase handshake.
    task automatic core_txn(input logic [HW-1:0] res, input int dly, input bit rnd_ready,
                            input bit abort_it, input logic [NCH-1:0] late,
                            output int got_ch, output logic [RW-1:0] got_data, output bit ok);
        int n;
        ok = 1'b1;
        n  = 0;
        while (hash_go !== 1'b1 && n < 60) begin
            hash_ready = (rnd_ready && n < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        if (hash_go !== 1'b1) begin
            ok = 1'b0;
            got_ch = -1;
            got_data = '0;
            return;
        end
        got_ch   = int'(grant_id);
        got_data = hash_data;
        req_go   = req_go | late;
        if (abort_it) req_go[got_ch] = 1'b0;
        repeat (dly) tick();
        hash_done   = 1'b1;
        hash_result = res;
        n = 0;
        do begin
            tick();
            n++;
        end while (hash_go === 1'b1 && n < 60);
        if (hash_go !== 1'b0) ok = 1'b0;
        hash_done   = 1'b0;
        hash_result = rnd_hash();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int n = 0; n < 2; n++) begin
            req_go      = NCH'($urandom);
            hash_ready  = 1'($urandom);
            hash_done   = 1'($urandom);
            hash_result = rnd_hash();
            load_payloads();
            tick();
            total++;
            if ({req_done, req_err, hash_go, busy} !== 10'b0) begin
                bad++;
                $display("FAIL reset_ctrl got=%b want=0", {req_done, req_err, hash_go, busy});
            end
            total++;
            if (hash_data !== '0 || grant_id !== '0) begin
                bad++;
                $display("FAIL reset_data got=%h/%0d want=0/0", hash_data, grant_id);
            end
            total++;
            if (req_hashed !== '0) begin
                bad++;
                $display("FAIL reset_hashed got=%0d_set_bits want=0", $countones(req_hashed));
            end
        end
        req_go = '0; hash_ready = 1'b0; hash_done = 1'b0;
        rst = 1'b1;
        m_ptr = NCH - 1;
        for (int c = 0; c < NCH; c++) m_hashed[c] = '0;
        load_payloads();
        tick();
    endtask

    task automatic test_single();
        req_go = 4'b0001;
        hash_ready = 1'b1;
        tick();
        total++;
        if ({hash_go, busy, grant_id} !== {1'b0, 1'b1, 2'd0}) begin
            bad++;
            $display("FAIL single_grant got=%b want=0100", {hash_go, busy, grant_id});
        end
        tick();
        total++;
        if (hash_go !== 1'b1 || hash_data !== m_pay[0]) begin
            bad++;
            $display("FAIL single_issue got=%b/%h want=1/%h", hash_go, hash_data, m_pay[0]);
        end
        repeat (2) tick();
        hash_done = 1'b1;
        hash_result = HW'(300);
        tick();
        total++;
        if (hash_go !== 1'b0 || req_done !== 4'b0000) begin
            bad++;
            $display("FAIL single_capture got=%b/%b want=0/0000", hash_go, req_done);
        end
        hash_done = 1'b0;
        tick();
        total++;
        if (req_done !== 4'b0001 || req_hashed[0 +: HW] !== HW'(300) || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_done got=%b/%0d/%b want=0001/300/0", req_done, req_hashed[0 +: HW], busy);
        end
        m_hashed[0] = HW'(300);
        m_ptr = 0;
        repeat (2) tick();
        total++;
        if (req_done !== 4'b0001) begin
            bad++;
            $display("FAIL single_hold got=%b want=0001", req_done);
        end
        req_go = '0;
        repeat (2) tick();
        total++;
        if (req_done !== 4'b0000 || req_hashed[0 +: HW] !== HW'(300)) begin
            bad++;
            $display("FAIL single_release got=%b/%0d want=0000/300", req_done, req_hashed[0 +: HW]);
        end
        tick();
    endtask

    task automatic test_all_channels();
        int ch;
        bit ok;
        logic [RW-1:0] d;
        logic [HW-1:0] r;
        test_reset();
        req_go = 4'b1111;
        for (int k = 0; k < NCH; k++) begin
            r = rnd_hash();
            core_txn(r, $urandom_range(0, 4), 1'b0, 1'b0, '0, ch, d, ok);
            total++;
            if (!ok || ch !== k || d !== m_pay[k]) begin
                bad++;
                $display("FAIL all_order got=%0d/%h ok=%0d want=%0d/%h", ch, d, ok, k, m_pay[k]);
            end
            m_hashed[k] = r;
            m_ptr = k;
        end
        tick();
        total++;
        if (req_done !== 4'b1111) begin
            bad++;
            $display("FAIL all_done got=%b want=1111", req_done);
        end
        for (int c = 0; c < NCH; c++) begin
            total++;
            if (req_hashed[c*HW +: HW] !== m_hashed[c]) begin
                bad++;
                $display("FAIL all_hashed%0d got=%h want=%h", c, req_hashed[c*HW +: HW], m_hashed[c]);
            end
        end
        release_all();
    endtask

    task automatic test_backpressure();
        int c, ch;
        bit ok;
        logic [RW-1:0] d;
        logic [HW-1:0] r;
        c = (m_ptr + 2) % NCH;
        req_go = 4'b0001 << c;
        hash_ready = 1'b0;
        tick();
        for (int n = 0; n < 10; n++) begin
            tick();
            total++;
            if (hash_go !== 1'b0 || busy !== 1'b1 || grant_id !== 2'(c)) begin
                bad++;
                $display("FAIL bp_hold got=%b/%b/%0d want=0/1/%0d", hash_go, busy, grant_id, c);
            end
        end
        hash_ready = 1'b1;
        tick();
        total++;
        if (hash_go !== 1'b1) begin
            bad++;
            $display("FAIL bp_release got=%b want=1", hash_go);
        end
        r = rnd_hash();
        core_txn(r, 1, 1'b0, 1'b0, '0, ch, d, ok);
        total++;
        if (!ok || ch !== c || d !== m_pay[c]) begin
            bad++;
            $display("FAIL bp_txn got=%0d/%h ok=%0d want=%0d/%h", ch, d, ok, c, m_pay[c]);
        end
        m_hashed[c] = r;
        m_ptr = c;
        release_all();
        total++;
        if (req_hashed[c*HW +: HW] !== m_hashed[c]) begin
            bad++;
            $display("FAIL bp_hashed got=%h want=%h", req_hashed[c*HW +: HW], m_hashed[c]);
        end
    endtask

    task automatic test_abort();
        int ch;
        bit ok;
        logic [RW-1:0] d;
        logic [HW-1:0] r;
        test_reset();
        // Seed channel 1 with a known result, then move the pointer to 0.
        for (int s = 0; s < 2; s++) begin
            req_go = (s == 0) ? 4'b0010 : 4'b0001;
            r = rnd_hash();
            core_txn(r, 1, 1'b0, 1'b0, '0, ch, d, ok);
            total++;
            if (!ok || ch !== 1 - s) begin
                bad++;
                $display("FAIL abort_seed got=%0d ok=%0d want=%0d", ch, ok, 1 - s);
            end
            m_hashed[1 - s] = r;
            m_ptr = 1 - s;
            release_all();
        end
        req_go = 4'b0110;
        core_txn(rnd_hash(), 2, 1'b0, 1'b1, '0, ch, d, ok);
        total++;
        if (!ok || ch !== 1) begin
            bad++;
            $display("FAIL abort_grant got=%0d ok=%0d want=1", ch, ok);
        end
        m_ptr = 1;
        r = rnd_hash();
        core_txn(r, 1, 1'b0, 1'b0, '0, ch, d, ok);
        total++;
        if (!ok || ch !== 2 || d !== m_pay[2]) begin
            bad++;
            $display("FAIL abort_next got=%0d/%h ok=%0d want=2/%h", ch, d, ok, m_pay[2]);
        end
        m_hashed[2] = r;
        m_ptr = 2;
        tick();
        total++;
        if (req_done !== 4'b0100) begin
            bad++;
            $display("FAIL abort_done got=%b want=0100", req_done);
        end
        for (int c = 0; c < NCH; c++) begin
            total++;
            if (req_hashed[c*HW +: HW] !== m_hashed[c]) begin
                bad++;
                $display("FAIL abort_hashed%0d got=%h want=%h", c, req_hashed[c*HW +: HW], m_hashed[c]);
            end
        end
        release_all();
    endtask

    task automatic test_random();
        logic [NCH-1:0] gm, late, served;
        int exp, ch;
        bit ok, first;
        logic [RW-1:0] d;
        logic [HW-1:0] r;
        for (int round = 0; round < 12; round++) begin
            load_payloads();
            gm     = NCH'($urandom_range(1, 15));
            late   = NCH'($urandom) & ~gm;
            served = '0;
            first  = 1'b1;
            req_go = gm;
            while ((gm & ~served) != '0) begin
                exp = rr_pick(gm & ~served, m_ptr);
                r = rnd_hash();
                core_txn(r, $urandom_range(0, 5), 1'b1, 1'b0, first ? late : '0, ch, d, ok);
                total++;
                if (!ok || ch !== exp || d !== m_pay[exp]) begin
                    bad++;
                    $display("FAIL rand_grant r%0d got=%0d/%h ok=%0d want=%0d/%h", round, ch, d, ok, exp, m_pay[exp]);
                end
                m_hashed[exp] = r;
                m_ptr = exp;
                served[exp] = 1'b1;
                if (first) gm = gm | late;
                first = 1'b0;
                if (!ok) break;
            end
            tick();
            total++;
            if (req_done !== gm) begin
                bad++;
                $display("FAIL rand_done r%0d got=%b want=%b", round, req_done, gm);
            end
            for (int c = 0; c < NCH; c++) begin
                total++;
                if (req_hashed[c*HW +: HW] !== m_hashed[c]) begin
                    bad++;
                    $display("FAIL rand_hashed%0d r%0d got=%h want=%h", c, round, req_hashed[c*HW +: HW], m_hashed[c]);
                end
            end
            release_all();
            total++;
            if (req_done !== '0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rand_release r%0d got=%b/%b want=0000/0", round, req_done, busy);
            end
        end
    endtask

`ifdef HASH_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int a, b, n, cnt, ch;
        bit ok;
        logic [RW-1:0] d;
        logic [HW-1:0] r;
        a = (m_ptr + 1) % NCH;
        b = (m_ptr + 3) % NCH;
        req_go = (4'b0001 << a) | (4'b0001 << b);
        hash_ready = 1'b1;
        n = 0;
        while (hash_go !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (hash_go !== 1'b1 || grant_id !== 2'(a)) begin
            bad++;
            $display("FAIL tmo_grant got=%b/%0d want=1/%0d", hash_go, grant_id, a);
        end
        m_ptr = a;
        cnt = 0;
        n = 0;
        while (hash_go === 1'b1 && n < 100) begin
            cnt++;
            tick();
            n++;
        end
        total++;
        if (cnt !== TMO) begin
            bad++;
            $display("FAIL tmo_cycles got=%0d want=%0d", cnt, TMO);
        end
        tick();
        total++;
        if (req_err !== (4'b0001 << a) || req_done !== 4'b0000) begin
            bad++;
            $display("FAIL tmo_err got=%b/%b want=%b/0000", req_err, req_done, 4'b0001 << a);
        end
        r = rnd_hash();
        core_txn(r, 1, 1'b0, 1'b0, '0, ch, d, ok);
        total++;
        if (!ok || ch !== b) begin
            bad++;
            $display("FAIL tmo_next got=%0d ok=%0d want=%0d", ch, ok, b);
        end
        m_hashed[b] = r;
        m_ptr = b;
        tick();
        total++;
        if (req_err !== (4'b0001 << a) || req_done !== (4'b0001 << b) || req_hashed[a*HW +: HW] !== m_hashed[a]) begin
            bad++;
            $display("FAIL tmo_after got=%b/%b want=%b/%b", req_err, req_done, 4'b0001 << a, 4'b0001 << b);
        end
        release_all();
        total++;
        if (req_err !== 4'b0000) begin
            bad++;
            $display("FAIL tmo_clear got=%b want=0000", req_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_all_channels();
        test_backpressure();
        test_abort();
        test_random();
`ifdef HASH_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ecies_hash_arbiter.md
Name: ecies_hash_arbiter

Overview:
- Shares one SHA hash core among NUM_CH independent hash requesters, for example encrypter KDF, decrypter KDF, encrypter MAC and decrypter MAC.
- Replaces the per-requester hashGo/hashDone wiring that ECIES_top exposes today. Each port keeps its own level handshake.
- Arbitration is round-robin. Results are stored per channel, so one slow requester never stalls the others.

Parameters:
- NUM_CH, 4, number of requester channels (2..8).
- REQ_WIDTH, 80, request payload width (integer_size+16).
- HASH_WIDTH, 512, hash result width.
- TIMEOUT_CYCLES, 1024, WAIT-state timeout; used only with HASH_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- req_go  in  NUM_CH  per-channel request level; held high until that channel's req_done is seen.
- req_data  in  NUM_CH*REQ_WIDTH  packed payloads; channel i is [i*REQ_WIDTH +: REQ_WIDTH]; must be stable while req_go[i] is high.
- req_done  out  NUM_CH  per-channel completion level.
- req_hashed  out  NUM_CH*HASH_WIDTH  per-channel result registers.
- req_err  out  NUM_CH  per-channel timeout flag.
- hash_ready  in  1  core can accept a request.
- hash_go  out  1  request to the core.
- hash_data  out  REQ_WIDTH  payload of the granted channel.
- hash_done  in  1  core completion level.
- hash_result  in  HASH_WIDTH  core output, valid while hash_done is high.
- grant_id  out  $clog2(NUM_CH)  channel currently granted.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0 at a clock edge): every output is 0, state is IDLE, round-robin pointer is NUM_CH-1. Reset mid-operation aborts immediately with hash_go=0 and all done/err flags cleared.
- Pending condition: pending[i] = req_go[i] & ~done_flag[i] & ~err_flag[i].
- Release: done_flag[i] and err_flag[i] clear in the first cycle req_go[i] is sampled low. A channel is re-armed only after its go has dropped.
- Outputs: req_done = done_flag and req_err = err_flag, both registered.
- IDLE: if any pending bit is set, grant the first pending channel searching upward from pointer+1 with wrap-around. Latch the grant into grant_id, set pointer = grant, go to ISSUE. Otherwise stay in IDLE.
- ISSUE: hash_data = the granted payload (registered). When hash_ready=1, set hash_go<=1 and go to WAIT. Otherwise hold in ISSUE.
- WAIT: hash_go stays high and hash_data stays stable. When hash_done=1:
  - capture hash_result into req_hashed[grant];
  - set done_flag[grant];
  - hash_go<=0;
  - go to RELEASE.
- RELEASE: wait for hash_done=0, then go to IDLE. This is a 4-phase handshake with the core.
- Abort: if req_go[grant] drops during ISSUE or WAIT, the transaction still completes with the core. The result is discarded and done_flag is not set.
- Latency:
  - req_go[i] rising, with the arbiter idle and hash_ready=1, gives hash_go=1 two edges later.
  - hash_done sampled at edge m gives req_done[i]=1 after edge m+1.
  - Minimum turnaround between back-to-back grants is 2 cycles after hash_done falls.
- Simultaneous events:
  - Requests from all channels in the same cycle are served in rotation from pointer+1.
  - A new request arriving during WAIT is served in the next IDLE.
  - If a channel's go falls in the same cycle its done is set, done_flag is cleared.
- req_hashed[i] holds its last value until overwritten or reset. It is not cleared on release.

Optional Feature:
- Macro: HASH_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT. On reaching TIMEOUT_CYCLES without hash_done, set hash_go<=0 and err_flag[grant], and go to RELEASE.
  - req_err[i] stays high until req_go[i] drops. req_done is not set for that transaction.
- Not defined:
  - No counter is instantiated. WAIT persists until hash_done.
  - req_err is tied to 0.

Test Plan:
- Reset with rst=0 for 2 cycles while all inputs toggle -> every output is 0 and busy=0.
- Single request: req_go=4'b0001, hash_ready=1, core returns 512'd300 three cycles after hash_go -> hash_go high two edges after go; hash_data equals channel 0 payload; req_hashed[0]=300; req_done[0]=1 until go drops.
- All four channels raise go together after reset -> grants are issued in order 0,1,2,3. Each req_hashed[i] holds its own distinct core value, with no cross-channel corruption.
- Backpressure: hold hash_ready=0 for 10 cycles -> ISSUE holds, hash_go stays 0, busy=1. Release hash_ready -> hash_go rises next edge.
- Abort: drop req_go[1] during WAIT -> req_done[1] stays 0 and req_hashed[1] is unchanged. A pending channel 2 is granted after the hash_done handshake completes.
- With HASH_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, hash_done never asserts -> hash_go drops after 16 WAIT cycles, req_err[grant]=1, and the next pending channel is granted.
